// File: rtl/featuremap_stream_ctrl.sv
// rtl/featuremap_stream_ctrl.sv - pads one frame with a zero border from lockstep channel FIFOs
// and counts the conv/bias results to flag frame completion.
module featuremap_stream_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int CHANNELS   = 8,
  parameter int OUT_PIXELS = WIDTH * WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CHANNELS-1:0]            fifo_empty,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  output logic                           rdreq,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                           valid_out,
  input  logic                           result_valid,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           err
);
  localparam int PW = $clog2(WIDTH + 2);
  localparam int CW = $clog2(OUT_PIXELS + 1);
  localparam logic [PW-1:0] P_LAST = PW'(WIDTH + 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(OUT_PIXELS);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [PW-1:0]                  r_row;
  logic [PW-1:0]                  r_col;
  logic [CW-1:0]                  r_cnt;
  logic [CHANNELS*DATA_WIDTH-1:0] r_data;
  logic                           r_valid;
  logic                           r_err;
  logic                           w_border;
  logic                           w_last;
  logic                           w_cnt_full;
  logic                           w_advance;
  logic                           w_start_ok;
  logic                           w_count_en;

  assign w_border   = (r_row == '0) || (r_row == P_LAST) || (r_col == '0) || (r_col == P_LAST);
  assign w_last     = (r_row == P_LAST) && (r_col == P_LAST);
  assign w_cnt_full = (r_cnt == C_FULL);
  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_count_en = result_valid && !w_cnt_full && ((r_state == S_RUN) || (r_state == S_DRAIN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_advance  = 1'b0;
    rdreq      = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        // a stalled interior pixel holds its position; border pixels never wait on the FIFOs
        w_advance = w_border || !(|fifo_empty);
        rdreq     = !w_border && !(|fifo_empty);
        if (w_advance && w_last) w_next = w_cnt_full ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_cnt_full) w_next = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_start_ok) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_advance) begin
      if (r_col == P_LAST) begin
        r_col <= '0;
        r_row <= w_last ? '0 : r_row + P_ONE;
      end else begin
        r_col <= r_col + P_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_start_ok)      r_cnt <= '0;
      else if (w_count_en) r_cnt <= r_cnt + C_ONE;
      if (result_valid && ((r_state == S_IDLE) || (r_state == S_DONE) || w_cnt_full)) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_advance;
      r_data  <= (w_advance && !w_border) ? data_in : '0;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign err       = r_err;
endmodule
